counter_day: RTL and testbench
==============================

# counter_day

Day-of-month counter for the digital clock's calendar chain, sitting directly upstream of the month counter. It advances once per `day_clk` edge and wraps at the true month length, including Gregorian leap years. On each wrap it drives `month_clk` as the month counter's advance strobe. It also accepts a user day-set request over a load/acknowledge handshake, clamping the requested day to the current month length.

## Interface
Parameters:
- `YEAR_W`, 12: width of `year_in`; legal years are 0 .. 2^YEAR_W-1.

Ports:
- `day_clk`  in  1  the block's only clock; each rising edge is one day tick.
- `rst`  in  1  reset, asynchronous, active-high; overrides everything.
- `en`  in  1  count enable; low freezes the day count.
- `month_in`  in  7  current month from the month counter, 0 = January .. 11 = December.
- `year_in`  in  YEAR_W  current year, binary.
- `load`  in  1  day-set request (level).
- `set_day`  in  5  requested day, 1..31.
- `load_ack`  out  1  registered one-cycle acknowledge of a captured load.
- `day_w`  out  5  current day of month, 1..31, registered.
- `month_clk`  out  1  registered one-cycle pulse on each month wrap.

## Operation
- Month length `last_day` is combinational from `month_in` and `year_in`:
  - 31 for months 0, 2, 4, 6, 7, 9, 11.
  - 30 for months 3, 5, 8, 10.
  - Month 1 is 29 if leap, otherwise 28.
  - `month_in` ≥ 12 is treated as 31.
- Leap rule: divisible by 4, and either not divisible by 100 or divisible by 400. So 2024 and 2000 are leap; 1900 and 2023 are not.
- Count step, when `en`=1 and no load is captured this edge:
  - If `day_w` ≥ `last_day`, then `day_w` becomes 1 and `month_clk` becomes 1.
  - Otherwise `day_w` increments by 1 and `month_clk` becomes 0.
- The ≥ compare covers an external month change that leaves `day_w` above the new `last_day` (e.g. day 31 with the month now April). The next step wraps to 1 and pulses `month_clk`.
- `en`=0: `day_w` holds and `month_clk` is 0. Loads are still accepted.
- Load handshake FSM, states IDLE, ACK, WAIT_LOW:
  - IDLE, `load`=1: capture `set_day` this edge and go to ACK. The captured value is clamped:
    - `set_day` = 0 becomes 1.
    - `set_day` > `last_day` becomes `last_day`.
  - ACK: `load_ack`=1 for exactly this cycle. If `load`=1 go to WAIT_LOW, else go to IDLE.
  - WAIT_LOW: stay until `load`=0, then go to IDLE. No further captures occur while here, so a held `load` produces exactly one capture.
- Priority per edge: `rst` > load capture > count step. On a capture edge:
  - `day_w` takes the clamped value.
  - `month_clk` is 0, even if a wrap would otherwise occur.
  - No count step is taken.
- Counting continues normally while the FSM is in ACK or WAIT_LOW.

## Timing
- Reset values: `day_w`=1, `month_clk`=0, `load_ack`=0, FSM in IDLE.
- Reset acts immediately on assertion, independent of `day_clk`. Reset mid-handshake abandons the load. If `load` is still high after reset release, it is captured at the next edge.
- `day_w` and `month_clk` change only on `day_clk` rising edges, one edge after the qualifying conditions are sampled.
- `month_clk` rises on the same edge that sets `day_w` to 1 and falls on the next edge. The month counter therefore sees its rising edge once per wrap.
- Load latency:
  - `day_w` shows the clamped value after the capture edge.
  - `load_ack` is high for the following cycle, i.e. 1 cycle after capture, lasting 1 cycle.
- `last_day` uses `month_in`/`year_in` as sampled at the step or capture edge. No registering of those inputs.

## Test plan
- Reset, then `month_in`=0, `en`=1, 31 edges:
  - `day_w` runs 1..31.
  - On the 31st edge `day_w`=1 and `month_clk`=1 for one cycle only.
- `month_in`=1, at day 28:
  - `year_in`=2024: next edge gives 29, then wrap with pulse.
  - `year_in`=2000: next edge gives 29, then wrap with pulse.
  - `year_in`=1900: next edge wraps 28→1 with pulse.
  - `year_in`=2023: next edge wraps 28→1 with pulse.
- `month_in`=3, `set_day`=31, `load` held high for 4 cycles:
  - `day_w`=30 after capture.
  - `load_ack` high for exactly one cycle.
  - No second capture.
  - `set_day`=0 then loads as 1.
- `en`=0 for 5 edges at day 12: `day_w` stays 12 and `month_clk` stays 0. After `en`=1, the next edge gives 13.
- Load while at day 31 of January, with `set_day`=5 on the would-be wrap edge: `day_w`=5, `month_clk`=0.
- Assert `rst` between edges in the FSM's ACK state: `day_w`=1 and `load_ack`=0 immediately. Counting resumes from 1 after release.

Source files
------------

// File: rtl/counter_day_if.sv
// Day-counter bus: calendar inputs and load request toward the counter; day, wrap strobe and ack back.
// The controller side drives the master modport; the counter implements the slave modport.
interface counter_day_if #(
  parameter int YEAR_W = 12
);
  logic              en;
  logic [6:0]        month_in;
  logic [YEAR_W-1:0] year_in;
  logic              load;
  logic [4:0]        set_day;
  logic              load_ack;
  logic [4:0]        day_w;
  logic              month_clk;

  modport master (
    output en, month_in, year_in, load, set_day,
    input  load_ack, day_w, month_clk
  );

  modport slave (
    input  en, month_in, year_in, load, set_day,
    output load_ack, day_w, month_clk
  );
endinterface

// File: rtl/counter_day.sv
// Day-of-month counter with Gregorian month length: one day per edge, 1-cycle registered outputs.
// No backpressure; a level load is taken once per assertion, and load_ack pulses while the FSM is in ACK.
module counter_day #(
  parameter int YEAR_W = 12
) (
  input  logic         day_clk,
  input  logic         rst,
  counter_day_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACK, WAIT_LOW} ld_state_t;

  ld_state_t   state_q, state_d;
  logic        capture;
  logic        leap;
  logic [4:0]  last_day;
  logic [4:0]  clamped;
  logic [31:0] year32;
  logic [4:0]  day_q;
  logic        month_clk_q;
  logic        load_ack_q;

  assign year32 = {{(32 - YEAR_W){1'b0}}, bus.year_in};
  assign leap   = (year32[1:0] == 2'b00) &&
                  (((year32 % 32'd100) != 32'd0) || ((year32 % 32'd400) == 32'd0));

  always_comb begin
    last_day = 5'd31;
    case (bus.month_in)
      7'd1:                      last_day = leap ? 5'd29 : 5'd28;
      7'd3, 7'd5, 7'd8, 7'd10:   last_day = 5'd30;
      default:                   last_day = 5'd31;
    endcase
  end

  always_comb begin
    clamped = bus.set_day;
    if (bus.set_day == 5'd0)
      clamped = 5'd1;
    else if (bus.set_day > last_day)
      clamped = last_day;
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.load) begin
          capture = 1'b1;
          state_d = ACK;
        end
      end
      ACK:      state_d = bus.load ? WAIT_LOW : IDLE;
      WAIT_LOW: if (!bus.load) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge day_clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      day_q       <= 5'd1;
      month_clk_q <= 1'b0;
      load_ack_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_ack_q <= capture;
      if (capture) begin
        day_q       <= clamped;
        month_clk_q <= 1'b0;
      end else if (bus.en) begin
        // >= rather than == so a day stranded past a shorter new month still wraps
        if (day_q >= last_day) begin
          day_q       <= 5'd1;
          month_clk_q <= 1'b1;
        end else begin
          day_q       <= day_q + 5'd1;
          month_clk_q <= 1'b0;
        end
      end else begin
        month_clk_q <= 1'b0;
      end
    end
  end

  assign bus.day_w     = day_q;
  assign bus.month_clk = month_clk_q;
  assign bus.load_ack  = load_ack_q;

endmodule

// File: tb/tb_counter_day.sv
// Bench for counter_day: vector table, directed calendar/handshake sequences, then random traffic vs. a model.
module tb_counter_day;

  logic day_clk = 1'b0;
  logic rst     = 1'b1;
  int   checks  = 0;
  int   errors  = 0;

  counter_day_if #(.YEAR_W(12)) bus ();

  counter_day #(.YEAR_W(12)) dut (
    .day_clk (day_clk),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 day_clk = ~day_clk;

  // reference model state
  int m_day  = 1;
  int m_mclk = 0;
  int m_ack  = 0;
  int m_busy = 0;
  int mdays[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};

  function automatic int mlen(int m, int y);
    bit lp;
    lp = (y % 4 == 0) && ((y % 100 != 0) || (y % 400 == 0));
    if (m >= 12) return 31;
    if (m == 1 && lp) return 29;
    return mdays[m];
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_day = 1; m_mclk = 0; m_ack = 0; m_busy = 0;
  endtask

  task automatic model_step();
    int  ld;
    int  sd;
    bit  cap;
    ld  = mlen(int'(bus.month_in), int'(bus.year_in));
    sd  = int'(bus.set_day);
    cap = (m_busy == 0) && bus.load;
    m_ack = cap ? 1 : 0;
    if (cap) begin
      m_day  = (sd == 0) ? 1 : ((sd > ld) ? ld : sd);
      m_mclk = 0;
      m_busy = 1;
    end else begin
      if (m_busy != 0 && !bus.load) m_busy = 0;
      if (bus.en) begin
        if (m_day >= ld) begin m_day = 1; m_mclk = 1; end
        else begin m_day = m_day + 1; m_mclk = 0; end
      end else begin
        m_mclk = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge day_clk);
    model_step();
    #1;
    chk("day", int'(bus.day_w), m_day);
    chk("month_clk", int'(bus.month_clk), m_mclk);
    chk("load_ack", int'(bus.load_ack), m_ack);
  endtask

  task automatic drive(bit e, int m, int y, bit l, int sd);
    bus.en = e; bus.month_in = 7'(m); bus.year_in = 12'(y); bus.load = l; bus.set_day = 5'(sd);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    model_reset();
    chk("rst_day", int'(bus.day_w), 1);
    chk("rst_mclk", int'(bus.month_clk), 0);
    chk("rst_ack", int'(bus.load_ack), 0);
    rst = 1'b0;
  endtask

  typedef struct {
    bit en; int month; int year; bit load; int sd;
    int exp_day; int exp_mclk; int exp_ack;
  } vec_t;

  vec_t vt[13];

  initial begin
    int ack_cnt;
    int yrs[4];
    drive(1'b0, 0, 2024, 1'b0, 0);

    vt[0]  = '{1, 0,  2024, 0, 0,  2,  0, 0};
    vt[1]  = '{1, 0,  2024, 1, 31, 31, 0, 1};
    vt[2]  = '{1, 0,  2024, 0, 0,  1,  1, 0};
    vt[3]  = '{1, 0,  2024, 0, 0,  2,  0, 0};
    vt[4]  = '{0, 0,  2024, 0, 0,  2,  0, 0};
    vt[5]  = '{0, 0,  2024, 1, 0,  1,  0, 1};
    vt[6]  = '{0, 0,  2024, 1, 0,  1,  0, 0};
    vt[7]  = '{1, 1,  2023, 1, 20, 2,  0, 0};
    vt[8]  = '{1, 1,  2023, 0, 0,  3,  0, 0};
    vt[9]  = '{1, 1,  1900, 1, 30, 28, 0, 1};
    vt[10] = '{1, 1,  1900, 0, 0,  1,  1, 0};
    vt[11] = '{1, 14, 2024, 1, 31, 31, 0, 1};
    vt[12] = '{1, 3,  2024, 0, 0,  1,  1, 0};

    #12;
    do_reset();

    for (int i = 0; i < 13; i++) begin
      drive(vt[i].en, vt[i].month, vt[i].year, vt[i].load, vt[i].sd);
      tick();
      chk($sformatf("vec%0d_day", i), int'(bus.day_w), vt[i].exp_day);
      chk($sformatf("vec%0d_mclk", i), int'(bus.month_clk), vt[i].exp_mclk);
      chk($sformatf("vec%0d_ack", i), int'(bus.load_ack), vt[i].exp_ack);
    end

    // January run from reset: 31 edges, pulse only on the wrap edge
    drive(1'b0, 0, 2024, 1'b0, 0);
    do_reset();
    bus.en = 1'b1;
    for (int i = 1; i <= 31; i++) begin
      tick();
      chk("jan_day", int'(bus.day_w), (i % 31) + 1);
      chk("jan_mclk", int'(bus.month_clk), (i == 31) ? 1 : 0);
    end
    tick();
    chk("jan_pulse_end", int'(bus.month_clk), 0);

    // February in leap and non-leap years
    yrs = '{2024, 2000, 1900, 2023};
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1, yrs[k], 1'b1, 28);
      tick();
      chk("feb_load", int'(bus.day_w), 28);
      bus.load = 1'b0;
      tick();
      if (k < 2) begin
        chk("feb_leap29", int'(bus.day_w), 29);
        tick();
      end
      chk("feb_wrap_day", int'(bus.day_w), 1);
      chk("feb_wrap_mclk", int'(bus.month_clk), 1);
    end

    // April clamp with load held four cycles
    drive(1'b0, 3, 2024, 1'b1, 31);
    ack_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      ack_cnt += int'(bus.load_ack);
    end
    chk("apr_clamp", int'(bus.day_w), 30);
    chk("apr_ack_count", ack_cnt, 1);
    bus.load = 1'b0;
    tick();
    drive(1'b0, 3, 2024, 1'b1, 0);
    tick();
    chk("zero_to_one", int'(bus.day_w), 1);
    bus.load = 1'b0;
    tick();

    // frozen at day 12
    drive(1'b0, 0, 2024, 1'b1, 12);
    tick();
    bus.load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_day", int'(bus.day_w), 12);
      chk("hold_mclk", int'(bus.month_clk), 0);
    end
    bus.en = 1'b1;
    tick();
    chk("resume13", int'(bus.day_w), 13);

    // load wins over the Jan 31 wrap
    drive(1'b1, 0, 2024, 1'b1, 30);
    tick();
    bus.load = 1'b0;
    tick();
    chk("jan31", int'(bus.day_w), 31);
    drive(1'b1, 0, 2024, 1'b1, 5);
    tick();
    chk("wrap_load_day", int'(bus.day_w), 5);
    chk("wrap_load_mclk", int'(bus.month_clk), 0);
    bus.load = 1'b0;
    tick();

    // asynchronous reset while in ACK
    drive(1'b1, 0, 2024, 1'b1, 20);
    tick();
    chk("pre_rst_ack", int'(bus.load_ack), 1);
    drive(1'b1, 0, 2024, 1'b0, 0);
    do_reset();
    tick();
    chk("post_rst_day", int'(bus.day_w), 2);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      int yr;
      case ($urandom_range(0, 4))
        0: yr = 1900;
        1: yr = 2000;
        2: yr = 2023;
        3: yr = 2024;
        default: yr = $urandom_range(0, 4095);
      endcase
      drive(($urandom_range(0, 9) < 8), $urandom_range(0, 13), yr,
            ($urandom_range(0, 9) < 2), $urandom_range(0, 31));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
